// File: rtl/ex_mem_req_unit_pkg.sv
// Shared definitions for the EX-stage memory request engine and its lane-alignment helper.
`ifndef EX_ME_RESP_BUS_W
`define EX_ME_RESP_BUS_W(dw) ((dw) + 1)
`endif

package ex_mem_req_unit_pkg;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;
    localparam logic [1:0] MEM_SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Unshifted byte-enable pattern for an access of the given size.
    function automatic logic [7:0] size_base_strb(input logic [1:0] size);
        case (size)
            MEM_SIZE_B: size_base_strb = 8'h01;
            MEM_SIZE_H: size_base_strb = 8'h03;
            MEM_SIZE_W: size_base_strb = 8'h0F;
            default:    size_base_strb = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/ex_mem_req_unit_lane_align.sv
// Byte-lane alignment: size + low address bits -> shifted strobes/data and misalignment flag.
// Purely combinational; the ME load-extract path instantiates it as well.
module mem_lane_align
    import ex_mem_req_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]          size,
    input  logic [2:0]          addr_lo,
    input  logic [DATA_W-1:0]   wdata_in,
    output logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   wdata,
    output logic                misaligned
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    logic [OFF_W-1:0] off;
    logic [7:0]       base8;

    assign off   = addr_lo[OFF_W-1:0];
    assign base8 = size_base_strb(size);
    assign wstrb = STRB_W'(base8) << off;
    assign wdata = wdata_in << {off, 3'b000};

    always_comb begin
        misaligned = 1'b0;
        case (size)
            MEM_SIZE_H: misaligned = addr_lo[0];
            MEM_SIZE_W: misaligned = |addr_lo[1:0];
            MEM_SIZE_D: misaligned = |addr_lo[2:0];
            default:    misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_req_unit.sv
// EX-stage data-memory request engine: req/addr_ok/data_ok handshake, outstanding tracking,
// and silent discard of responses that belong to flushed instructions.
module ex_mem_req_unit
    import ex_mem_req_unit_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_OUTST = 2,
    parameter int CNT_W     = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                ex_valid,
    input  logic                ex_mem_rd,
    input  logic                ex_mem_wr,
    input  logic [1:0]          ex_size,
    input  logic [ADDR_W-1:0]   ex_addr,
    input  logic [DATA_W-1:0]   ex_wdata,
    output logic                ex_ready_go,
    output logic                ex_ale,
    output logic                req,
    output logic                req_wr,
    output logic [1:0]          req_size,
    output logic [DATA_W/8-1:0] req_wstrb,
    output logic [ADDR_W-1:0]   req_addr,
    output logic [DATA_W-1:0]   req_wdata,
    input  logic                addr_ok,
    input  logic                data_ok,
    input  logic [DATA_W-1:0]   rdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_data,
    output logic                outst_full
);
    localparam int               STRB_W  = DATA_W / 8;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e              state, state_nxt;
    logic [CNT_W-1:0]    outst_cnt, outst_nxt;
    logic [CNT_W-1:0]    cancel_cnt, cancel_nxt;
    logic                kill_pend, kill_nxt;
    logic                hold_wr;
    logic [1:0]          hold_size;
    logic [STRB_W-1:0]   hold_wstrb;
    logic [ADDR_W-1:0]   hold_addr;
    logic [DATA_W-1:0]   hold_wdata;

    logic [STRB_W-1:0]   lane_wstrb;
    logic [DATA_W-1:0]   lane_wdata;
    logic                misaligned;
    logic                mem_op;
    logic                issue;
    logic                accept;
    logic                cancel_hit;

    mem_lane_align #(.DATA_W(DATA_W)) u_lane_align (
        .size       (ex_size),
        .addr_lo    (ex_addr[2:0]),
        .wdata_in   (ex_wdata),
        .wstrb      (lane_wstrb),
        .wdata      (lane_wdata),
        .misaligned (misaligned)
    );

    assign mem_op     = ex_valid & (ex_mem_rd | ex_mem_wr);
    assign ex_ale     = mem_op & misaligned & ~flush;
    assign issue      = mem_op & ~misaligned & ~flush & (state == ST_IDLE)
                      & ((outst_cnt < MAX_CNT) | data_ok);
    assign req        = (state == ST_REQ);
    assign accept     = req & addr_ok;
    assign cancel_hit = data_ok & (cancel_cnt != '0);

    assign ex_ready_go = ~mem_op | ex_ale | (state == ST_DONE) | flush;
    assign resp_valid  = data_ok & (cancel_cnt == '0);
    assign resp_data   = rdata;
    assign outst_full  = (outst_cnt == MAX_CNT);

    assign req_wr    = hold_wr;
    assign req_size  = hold_size;
    assign req_wstrb = hold_wstrb;
    assign req_addr  = hold_addr;
    assign req_wdata = hold_wdata;

    always_comb begin
        state_nxt  = state;
        kill_nxt   = kill_pend;
        outst_nxt  = outst_cnt;
        cancel_nxt = cancel_cnt;

        if (accept && !data_ok)
            outst_nxt = outst_cnt + CNT_ONE;
        else if (!accept && data_ok)
            outst_nxt = outst_cnt - CNT_ONE;
        if (cancel_hit)
            cancel_nxt = cancel_cnt - CNT_ONE;

        case (state)
            ST_IDLE: begin
                if (issue) begin
                    state_nxt = ST_REQ;
                    kill_nxt  = 1'b0;
                end
            end
            // A request already on the bus cannot be withdrawn; a flush only marks it for discard.
            ST_REQ: begin
                if (accept) begin
                    kill_nxt = 1'b0;
                    if (kill_pend || flush) begin
                        state_nxt  = ST_IDLE;
                        cancel_nxt = cancel_nxt + CNT_ONE;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end else if (flush) begin
                    kill_nxt = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        // Every request still in flight belongs to a flushed instruction.
        if (flush && state != ST_REQ) begin
            cancel_nxt = outst_nxt;
            state_nxt  = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            outst_cnt  <= '0;
            cancel_cnt <= '0;
            kill_pend  <= 1'b0;
            hold_wr    <= 1'b0;
            hold_size  <= '0;
            hold_wstrb <= '0;
            hold_addr  <= '0;
            hold_wdata <= '0;
        end else begin
            state      <= state_nxt;
            outst_cnt  <= outst_nxt;
            cancel_cnt <= cancel_nxt;
            kill_pend  <= kill_nxt;
            if (issue) begin
                hold_wr    <= ex_mem_wr;
                hold_size  <= ex_size;
                hold_wstrb <= ex_mem_wr ? lane_wstrb : '0;
                hold_addr  <= ex_addr;
                hold_wdata <= lane_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (outst_cnt <= MAX_CNT);
            assert (cancel_cnt <= outst_cnt);
            assert (!(data_ok && outst_cnt == '0));
        end
    end

endmodule

// File: tb/tb_ex_mem_req_unit.sv
// Directed and randomized bench for ex_mem_req_unit against an in-order response queue model.
module tb_ex_mem_req_unit;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int MAX_OUTST = 2;
    localparam int CNT_W     = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_mem_rd = 1'b0;
    logic        ex_mem_wr = 1'b0;
    logic [1:0]  ex_size = 2'd0;
    logic [31:0] ex_addr = '0;
    logic [31:0] ex_wdata = '0;
    logic        ex_ready_go, ex_ale, req, req_wr;
    logic [1:0]  req_size;
    logic [3:0]  req_wstrb;
    logic [31:0] req_addr, req_wdata;
    logic        addr_ok = 1'b0;
    logic        data_ok = 1'b0;
    logic [31:0] rdata = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        outst_full;

    int tests = 0;
    int fails = 0;
    // One entry per accepted request, oldest first; 1 = its response must be discarded.
    bit killed_q[$];

    ex_mem_req_unit #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .ex_valid(ex_valid), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ex_size(ex_size), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_ready_go(ex_ready_go), .ex_ale(ex_ale),
        .req(req), .req_wr(req_wr), .req_size(req_size), .req_wstrb(req_wstrb),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .outst_full(outst_full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void lane_model(input logic [1:0] sz, input logic [31:0] addr,
                                       input logic [31:0] wd, output bit mis,
                                       output logic [3:0] strb, output logic [31:0] wdo);
        int nb;
        int off;
        nb   = 1 << sz;
        off  = int'(addr % 4);
        mis  = (addr % nb) != 0;
        strb = 4'(((1 << nb) - 1) << off);
        wdo  = 32'(64'(wd) << (8 * off));
    endfunction

    task automatic clear_ex();
        ex_valid  = 1'b0;
        ex_mem_rd = 1'b0;
        ex_mem_wr = 1'b0;
    endtask

    task automatic mem_access(input bit wr, input logic [1:0] sz, input logic [31:0] addr,
                              input logic [31:0] wd, input int delay);
        bit          mis;
        logic [3:0]  strb;
        logic [31:0] wdo;
        lane_model(sz, addr, wd, mis, strb, wdo);
        if (!wr) strb = 4'h0;
        ex_valid = 1'b1; ex_mem_rd = !wr; ex_mem_wr = wr;
        ex_size = sz; ex_addr = addr; ex_wdata = wd;
        #1;
        check("ale", ex_ale, mis);
        check("full_at_issue", outst_full, killed_q.size() == MAX_OUTST);
        check("req_idle", req, 1'b0);
        check("ready_issue", ex_ready_go, mis);
        tick();
        if (mis) begin
            clear_ex();
            #1;
            check("ale_no_req", req, 1'b0);
            tick();
            return;
        end
        for (int d = 0; d <= delay; d++) begin
            addr_ok = (d == delay);
            #1;
            check("req_high", req, 1'b1);
            check("req_addr", req_addr, addr);
            check("req_wr", req_wr, wr);
            check("req_size", req_size, sz);
            check("req_wstrb", req_wstrb, strb);
            check("req_wdata", req_wdata, wdo);
            check("ready_wait", ex_ready_go, 1'b0);
            tick();
        end
        addr_ok = 1'b0;
        killed_q.push_back(1'b0);
        #1;
        check("ready_done", ex_ready_go, 1'b1);
        check("req_dropped", req, 1'b0);
        tick();
        clear_ex();
    endtask

    task automatic respond(input logic [31:0] d);
        bit exp_v;
        bit dummy;
        exp_v   = !killed_q[0];
        data_ok = 1'b1;
        rdata   = d;
        #1;
        check("resp_valid", resp_valid, exp_v);
        check("resp_data", resp_data, d);
        check("full_resp", outst_full, killed_q.size() == MAX_OUTST);
        tick();
        data_ok = 1'b0;
        dummy = killed_q.pop_front();
    endtask

    task automatic flush_idle();
        flush = 1'b1;
        #1;
        check("flush_ready", ex_ready_go, 1'b1);
        tick();
        flush = 1'b0;
        foreach (killed_q[i]) killed_q[i] = 1'b1;
    endtask

    initial begin
        // Reset
        tick();
        #1;
        check("rst_req", req, 1'b0);
        check("rst_full", outst_full, 1'b0);
        check("rst_resp", resp_valid, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_req", req, 1'b0);
        tick();

        // Word store held for two cycles before acceptance
        mem_access(1'b1, 2'd2, 32'h1004, 32'hA5A5A5A5, 2);
        respond(32'h0);

        // Byte store to top lane, then misaligned halfword load
        mem_access(1'b1, 2'd0, 32'h1003, 32'h12, 0);
        mem_access(1'b0, 2'd1, 32'h1001, 32'h0, 0);
        respond(32'h0);

        // Third load stalls on full, issues on the data_ok cycle
        mem_access(1'b0, 2'd2, 32'h2000, 32'h0, 0);
        mem_access(1'b0, 2'd2, 32'h2004, 32'h0, 0);
        ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_size = 2'd2; ex_addr = 32'h2008;
        #1;
        check("stall_full", outst_full, 1'b1);
        check("stall_ready", ex_ready_go, 1'b0);
        tick();
        #1;
        check("stall_no_req", req, 1'b0);
        tick();
        data_ok = 1'b1; rdata = 32'h11111111;
        #1;
        check("stall_resp", resp_valid, 1'b1);
        tick();
        data_ok = 1'b0;
        void'(killed_q.pop_front());
        addr_ok = 1'b1;
        #1;
        check("unstall_req", req, 1'b1);
        check("unstall_addr", req_addr, 32'h2008);
        check("unstall_full", outst_full, 1'b0);
        tick();
        addr_ok = 1'b0;
        killed_q.push_back(1'b0);
        #1;
        check("unstall_done", ex_ready_go, 1'b1);
        tick();
        clear_ex();
        respond(32'h22222222);
        respond(32'h33333333);

        // Flush during REQ with late addr_ok
        ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_size = 2'd2; ex_addr = 32'h3000;
        #1;
        tick();
        flush = 1'b1;
        #1;
        check("fr_req", req, 1'b1);
        check("fr_ready", ex_ready_go, 1'b1);
        tick();
        flush = 1'b0;
        clear_ex();
        for (int d = 0; d < 3; d++) begin
            addr_ok = (d == 2);
            #1;
            check("fr_req_hold", req, 1'b1);
            check("fr_addr_hold", req_addr, 32'h3000);
            tick();
        end
        addr_ok = 1'b0;
        killed_q.push_back(1'b1);
        mem_access(1'b0, 2'd2, 32'h3004, 32'h0, 0);
        respond(32'h44444444);
        respond(32'h55555555);

        // Flush with two outstanding, then a new load
        mem_access(1'b0, 2'd2, 32'h4000, 32'h0, 1);
        mem_access(1'b1, 2'd1, 32'h4002, 32'hBEEF, 0);
        flush_idle();
        respond(32'h66666666);
        mem_access(1'b0, 2'd0, 32'h4007, 32'h0, 0);
        respond(32'h77777777);
        respond(32'h88888888);
        mem_access(1'b0, 2'd2, 32'h4008, 32'h0, 0);
        respond(32'h99999999);

        // Reset in REQ with one outstanding
        mem_access(1'b0, 2'd2, 32'h5000, 32'h0, 0);
        ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_size = 2'd2; ex_addr = 32'h5004;
        #1;
        tick();
        #1;
        check("r6_req", req, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_ex();
        killed_q.delete();
        #1;
        check("r6_req_low", req, 1'b0);
        check("r6_full", outst_full, 1'b0);
        tick();
        mem_access(1'b0, 2'd2, 32'h5008, 32'h0, 0);
        mem_access(1'b0, 2'd2, 32'h500C, 32'h0, 0);
        #1;
        check("r6_full_two", outst_full, 1'b1);
        respond(32'hAAAA0001);
        respond(32'hAAAA0002);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            if (killed_q.size() == MAX_OUTST || (killed_q.size() > 0 && $urandom_range(1) == 1))
                respond($urandom);
            if ($urandom_range(7) == 0) begin
                ex_valid = 1'b1; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0;
                ex_addr = $urandom;
                #1;
                check("nonmem_ready", ex_ready_go, 1'b1);
                check("nonmem_ale", ex_ale, 1'b0);
                tick();
                clear_ex();
                #1;
                check("nonmem_no_req", req, 1'b0);
                tick();
            end else begin
                mem_access(1'($urandom_range(1)), 2'($urandom_range(2)), $urandom, $urandom,
                           int'($urandom_range(3)));
            end
        end
        while (killed_q.size() > 0) respond($urandom);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
